// File: rtl/sequenciador_frames_pkg.sv
// Shared definitions for the frame sequencer: FSM state codes, pet-state
// (estado) codes and the display command preamble table.
package sequenciador_pkg;

  // FSM state encoding (kept as plain constants for legacy tools)
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_PRE     = 3'd1;
  localparam logic [2:0] ST_FETCH   = 3'd2;
  localparam logic [2:0] ST_PRESENT = 3'd3;
  localparam logic [2:0] ST_DONE    = 3'd4;

  // Pet state codes, one-hot with all-zero meaning idle
  typedef enum logic [3:0] {
    EST_IDLE       = 4'b0000,
    EST_DORMINDO   = 4'b0001,
    EST_COMENDO    = 4'b0010,
    EST_DANDO_AULA = 4'b0100,
    EST_MORTO      = 4'b1000
  } estado_t;

  // Column/page window commands sent ahead of the pixel data
  localparam int PREAMBLE_LEN = 6;

  function automatic logic [7:0] preamble_byte(input logic [2:0] idx);
    case (idx)
      3'd0:    return 8'h21;
      3'd1:    return 8'h00;
      3'd2:    return 8'h7F;
      3'd3:    return 8'h22;
      3'd4:    return 8'h00;
      3'd5:    return 8'h07;
      default: return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/sequenciador_frames_if.sv
// Bus between the frame sequencer, the image controller (address/state out,
// byte back) and the display transmitter (valid/ready byte stream).
interface sequenciador_frames_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] byte_counter;
  logic [3:0]        estado_img;
  logic [7:0]        img_data;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              tx_dc;

  // Sequencer side
  modport master (
    output byte_counter, estado_img, tx_data, tx_valid, tx_dc,
    input  img_data, tx_ready
  );

  // Image controller / transmitter side
  modport slave (
    input  byte_counter, estado_img, tx_data, tx_valid, tx_dc,
    output img_data, tx_ready
  );
endinterface

// File: rtl/sequenciador_frames_contador_animacao.sv
// Animation frame index: cleared when the pet state changes at frame start,
// stepped once per completed frame, wrapping modulo ANIM_FRAMES.
module contador_animacao #(
  parameter int ANIM_FRAMES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       step,
  output logic [2:0] frame_index
);

  localparam logic [2:0] LAST_FRAME = 3'(ANIM_FRAMES - 1);

  // Clear has priority over step; wrap back to 0 after the last frame
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_index <= 3'd0;
    end else if (clear) begin
      frame_index <= 3'd0;
    end else if (step) begin
      frame_index <= (frame_index == LAST_FRAME) ? 3'd0 : frame_index + 3'd1;
    end
  end

endmodule

// File: rtl/sequenciador_frames.sv
// Frame sequencer: on each frame tick, walks the image controller through
// NUM_BYTES addresses and streams the returned bytes to the display
// transmitter over valid/ready. Optional feature macro SEQ_CMD_PREAMBLE_EN
// prepends the 6-byte column/page window command sequence (tx_dc=0).
module sequenciador_frames
  import sequenciador_pkg::*;
#(
  parameter int NUM_BYTES   = 1024,
  parameter int ADDR_W      = 10,
  parameter int ANIM_FRAMES = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [3:0]                   estado,
  input  logic                         tick_frame,
  sequenciador_frames_if.master        bus,
  output logic [2:0]                   frame_index,
  output logic                         busy,
  output logic                         frame_done,
  output logic                         overrun
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_BYTES - 1);

  logic [2:0]        state;
  logic [ADDR_W-1:0] byte_counter;
  logic [3:0]        estado_img;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_dc;

  logic accept;
  logic start;
  logic anim_clear;
  logic anim_step;

  assign accept     = tx_valid && bus.tx_ready;
  assign start      = (state == ST_IDLE) && tick_frame;
  assign anim_clear = start && (estado != estado_img);
  assign anim_step  = (state == ST_DONE);

  assign bus.byte_counter = byte_counter;
  assign bus.estado_img   = estado_img;
  assign bus.tx_data      = tx_data;
  assign bus.tx_valid     = tx_valid;
  assign bus.tx_dc        = tx_dc;

`ifdef SEQ_CMD_PREAMBLE_EN
  logic [2:0] pre_idx;
  localparam logic [2:0] PRE_LAST = 3'(PREAMBLE_LEN - 1);

  // Data/command flag: low while the command preamble is on the bus
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_dc <= 1'b1;
    end else if (start) begin
      tx_dc <= 1'b0;
    end else if (state == ST_PRE && accept && pre_idx == PRE_LAST) begin
      tx_dc <= 1'b1;
    end
  end
`else
  assign tx_dc = 1'b1;
`endif

  // Main frame FSM: address generation, byte capture and handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      byte_counter <= '0;
      estado_img   <= 4'd0;
      tx_data      <= 8'd0;
      tx_valid     <= 1'b0;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      overrun      <= 1'b0;
`ifdef SEQ_CMD_PREAMBLE_EN
      pre_idx      <= 3'd0;
`endif
    end else begin
      frame_done <= 1'b0;
      // Any tick outside IDLE (including the DONE cycle) is dropped and flagged
      if (tick_frame && state != ST_IDLE) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (tick_frame) begin
            estado_img   <= estado;
            byte_counter <= '0;
            busy         <= 1'b1;
`ifdef SEQ_CMD_PREAMBLE_EN
            pre_idx      <= 3'd0;
            tx_data      <= preamble_byte(3'd0);
            tx_valid     <= 1'b1;
            state        <= ST_PRE;
`else
            state        <= ST_FETCH;
`endif
          end
        end
`ifdef SEQ_CMD_PREAMBLE_EN
        ST_PRE: begin
          if (accept) begin
            if (pre_idx == PRE_LAST) begin
              tx_valid <= 1'b0;
              state    <= ST_FETCH;
            end else begin
              pre_idx <= pre_idx + 3'd1;
              tx_data <= preamble_byte(pre_idx + 3'd1);
            end
          end
        end
`endif
        ST_FETCH: begin
          // Address has been stable for the ROM latency cycle; capture the byte
          tx_data  <= bus.img_data;
          tx_valid <= 1'b1;
          state    <= ST_PRESENT;
        end
        ST_PRESENT: begin
          if (accept) begin
            tx_valid <= 1'b0;
            if (byte_counter == LAST_ADDR) begin
              busy       <= 1'b0;
              frame_done <= 1'b1;
              state      <= ST_DONE;
            end else begin
              byte_counter <= byte_counter + ADDR_W'(1);
              state        <= ST_FETCH;
            end
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  contador_animacao #(
    .ANIM_FRAMES (ANIM_FRAMES)
  ) u_contador_animacao (
    .clk         (clk),
    .rst         (rst),
    .clear       (anim_clear),
    .step        (anim_step),
    .frame_index (frame_index)
  );

endmodule

// File: tb/tb_sequenciador_frames.sv
// Self-checking bench for sequenciador_frames: full frames with and without
// backpressure, estado change mid-frame, animation wrap, overrun and
// mid-frame reset. Honours SEQ_CMD_PREAMBLE_EN when defined.
module tb_sequenciador_frames;
  import sequenciador_pkg::*;

  localparam int NUM_BYTES = 1024;
  localparam int ADDR_W    = 10;
`ifdef SEQ_CMD_PREAMBLE_EN
  localparam int PRE_LEN = 6;
`else
  localparam int PRE_LEN = 0;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] estado;
  logic       tick_frame;
  logic [2:0] frame_index;
  logic       busy;
  logic       frame_done;
  logic       overrun;
  bit         rnd_ready;

  sequenciador_frames_if #(.ADDR_W(ADDR_W)) bus ();

  sequenciador_frames #(
    .NUM_BYTES   (NUM_BYTES),
    .ADDR_W      (ADDR_W),
    .ANIM_FRAMES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .estado      (estado),
    .tick_frame  (tick_frame),
    .bus         (bus),
    .frame_index (frame_index),
    .busy        (busy),
    .frame_done  (frame_done),
    .overrun     (overrun)
  );

  // Image ROM model: content depends on address and latched state
  function automatic logic [7:0] rom_byte(input logic [9:0] a, input logic [3:0] st);
    return (a[7:0] + ({6'b0, a[9:8]} * 8'd37)) ^ {st, st};
  endfunction

  assign bus.img_data = rom_byte(bus.byte_counter, bus.estado_img);

  logic [7:0] pre_tab [6] = '{8'h21, 8'h00, 8'h7F, 8'h22, 8'h00, 8'h07};

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transmitter ready: always 1, or random per cycle when backpressure is on
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.tx_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: record accepted bytes, count frame_done, check stall stability
  logic [7:0] got_data [$];
  bit         got_dc   [$];
  int         got_addr [$];
  int         got_fi   [$];
  int         fd_count = 0;
  bit         prev_stall = 0;
  logic [7:0] prev_data;
  logic       prev_dc;

  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", 32'(bus.tx_valid), 32'd1);
          check("hold_data", 32'(bus.tx_data), 32'(prev_data));
          check("hold_dc", 32'(bus.tx_dc), 32'(prev_dc));
        end
        if (bus.tx_valid && bus.tx_ready) begin
          got_data.push_back(bus.tx_data);
          got_dc.push_back(bus.tx_dc);
          got_addr.push_back(int'(bus.byte_counter));
          got_fi.push_back(int'(frame_index));
        end
        if (frame_done) fd_count++;
        prev_stall = bus.tx_valid && !bus.tx_ready;
        prev_data  = bus.tx_data;
        prev_dc    = bus.tx_dc;
      end
    end
  end

  task automatic pulse_tick();
    @(posedge clk);
    #1 tick_frame = 1'b1;
    @(posedge clk);
    #1 tick_frame = 1'b0;
  endtask

  // One full frame with expected stream built from the ROM model
  task automatic run_frame(input logic [3:0] st, input bit rnd, input int exp_fi,
                           input bit mid_change, input bit mid_tick, input int exp_ovr);
    logic [7:0] exp_d  [$];
    bit         exp_dc [$];
    int         exp_a  [$];
    int  base, fd_base, cycles, n, fi_first, fi_last;
    bit  changed, ticked, timed_out;
`ifdef SEQ_CMD_PREAMBLE_EN
    for (int i = 0; i < PRE_LEN; i++) begin
      exp_d.push_back(pre_tab[i]);
      exp_dc.push_back(1'b0);
      exp_a.push_back(0);
    end
`endif
    for (int i = 0; i < NUM_BYTES; i++) begin
      exp_d.push_back(rom_byte(10'(i), st));
      exp_dc.push_back(1'b1);
      exp_a.push_back(i);
    end
    estado    = st;
    rnd_ready = rnd;
    base      = got_data.size();
    fd_base   = fd_count;
    changed   = 0;
    ticked    = 0;
    timed_out = 1;
    cycles    = 0;
    pulse_tick();
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (frame_done) begin
        timed_out = 0;
        break;
      end
      if (mid_change && !changed && (got_data.size() - base) >= 500) begin
        estado  = EST_COMENDO;
        changed = 1;
      end
      if (mid_tick && !ticked && (got_data.size() - base) >= 100) begin
        tick_frame = 1'b1;
        ticked     = 1;
      end else begin
        tick_frame = 1'b0;
      end
      @(posedge clk);
      cycles++;
    end
    tick_frame = 1'b0;
    check("timeout", 32'(timed_out), 32'd0);
    check("busy_at_done", 32'(busy), 32'd0);
    if (!rnd) check("cycles", 32'(cycles), 32'(2 * NUM_BYTES + PRE_LEN));
    check("estado_img", 32'(bus.estado_img), 32'(st));
    repeat (3) @(negedge clk);
    check("fd_count", 32'(fd_count - fd_base), 32'd1);
    check("fd_pulse", 32'(frame_done), 32'd0);
    n = got_data.size() - base;
    check("len", 32'(n), 32'(exp_d.size()));
    for (int i = 0; i < n && i < exp_d.size(); i++) begin
      check("data", 32'(got_data[base + i]), 32'(exp_d[i]));
      check("dc", 32'(got_dc[base + i]), 32'(exp_dc[i]));
      check("addr", 32'(got_addr[base + i]), 32'(exp_a[i]));
    end
    fi_first = (n > 0) ? got_fi[base] : -1;
    fi_last  = (n > 0) ? got_fi[base + n - 1] : -1;
    check("fidx_first", 32'(fi_first), 32'(exp_fi));
    check("fidx_last", 32'(fi_last), 32'(exp_fi));
    check("fidx_next", 32'(frame_index), 32'((exp_fi == 3) ? 0 : exp_fi + 1));
    check("overrun", 32'(overrun), 32'(exp_ovr));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(bus.tx_valid), 32'd0);
    check({tag, "_dc"}, 32'(bus.tx_dc), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_addr"}, 32'(bus.byte_counter), 32'd0);
    check({tag, "_est"}, 32'(bus.estado_img), 32'd0);
    check({tag, "_fidx"}, 32'(frame_index), 32'd0);
    check({tag, "_done"}, 32'(frame_done), 32'd0);
    check({tag, "_ovr"}, 32'(overrun), 32'd0);
    check({tag, "_data"}, 32'(bus.tx_data), 32'd0);
  endtask

  initial begin
    int fd_base;
    bit reached;
    rst        = 1'b1;
    estado     = EST_IDLE;
    tick_frame = 1'b0;
    rnd_ready  = 0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    @(posedge clk);
    #1 rst = 1'b0;

    // Plain frame, then backpressure with estado change at byte 500
    run_frame(EST_DORMINDO, 0, 0, 0, 0, 0);
    run_frame(EST_DORMINDO, 1, 1, 1, 0, 0);
    // New estado clears the animation index; then walk the wrap 0,1,2,3,0
    run_frame(EST_COMENDO, 0, 0, 0, 0, 0);
    run_frame(EST_COMENDO, 0, 1, 0, 1, 1);
    run_frame(EST_COMENDO, 1, 2, 0, 0, 1);
    run_frame(EST_COMENDO, 0, 3, 0, 0, 1);
    run_frame(EST_COMENDO, 0, 0, 0, 0, 1);

    // Reset in the middle of a frame
    estado    = EST_COMENDO;
    rnd_ready = 0;
    fd_base   = fd_count;
    reached   = 0;
    begin
      int base;
      base = got_data.size();
      pulse_tick();
      for (int c = 0; c < 4000; c++) begin
        @(negedge clk);
        if ((got_data.size() - base) >= 300) begin
          reached = 1;
          break;
        end
      end
    end
    check("rst_wait", 32'(reached), 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("midrst");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst_no_done", 32'(fd_count - fd_base), 32'd0);
    check("midrst_idle", 32'(busy), 32'd0);
    run_frame(EST_COMENDO, 0, 0, 0, 0, 0);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
